// File: rtl/tape_pulse_gen.sv
// ROM-format tape EAR encoder: pilot, two sync pulses, MSB-first data bits and a pause,
// all timed in Z80 T-state strobes, with optional turbo halving of every pulse length.
module tape_pulse_gen #(
  parameter int PILOT_T     = 2168,
  parameter int SYNC1_T     = 667,
  parameter int SYNC2_T     = 735,
  parameter int BIT0_T      = 855,
  parameter int BIT1_T      = 1710,
  parameter int PILOT_HDR_N = 8063,
  parameter int PILOT_DAT_N = 3223,
  parameter int PAUSE_T     = 3500000,
  parameter int TURBO_SHIFT = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tstate_en,
  input  logic       i_save_turbo,
  input  logic       i_blk_start,
  input  logic       i_blk_is_hdr,
  input  logic [7:0] i_data,
  input  logic       i_data_last,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic       o_ear,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PILOT,
    ST_SYNC1,
    ST_SYNC2,
    ST_LOAD,
    ST_DATA,
    ST_PAUSE
  } state_t;

  localparam logic [12:0] PILOT_HDR_M1 = 13'(PILOT_HDR_N - 1);
  localparam logic [12:0] PILOT_DAT_M1 = 13'(PILOT_DAT_N - 1);
  localparam logic [21:0] PAUSE_M1     = 22'(PAUSE_T - 1);

  // Counter reload value for a pulse: one less than its (possibly turbo-scaled) length.
  function automatic logic [21:0] reload(input int t, input logic turbo);
    logic [21:0] full;
    full = 22'(t);
    if (turbo) full = full >> TURBO_SHIFT;
    return full - 22'd1;
  endfunction

  state_t      state_reg, state_next;
  logic [21:0] len_cnt_reg, len_cnt_next;
  logic [12:0] pilot_cnt_reg, pilot_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic        half_reg, half_next;
  logic [7:0]  byte_reg, byte_next;
  logic        last_reg, last_next;
  logic        turbo_reg, turbo_next;
  logic        ear_reg, ear_next;
  logic        done_reg, done_next;
  logic        underrun_reg, underrun_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg     <= ST_IDLE;
      len_cnt_reg   <= '0;
      pilot_cnt_reg <= '0;
      bit_idx_reg   <= '0;
      half_reg      <= 1'b0;
      byte_reg      <= '0;
      last_reg      <= 1'b0;
      turbo_reg     <= 1'b0;
      ear_reg       <= 1'b0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_cnt_reg   <= len_cnt_next;
      pilot_cnt_reg <= pilot_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      half_reg      <= half_next;
      byte_reg      <= byte_next;
      last_reg      <= last_next;
      turbo_reg     <= turbo_next;
      ear_reg       <= ear_next;
      done_reg      <= done_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_cnt_next   = len_cnt_reg;
    pilot_cnt_next = pilot_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    half_next      = half_reg;
    byte_next      = byte_reg;
    last_next      = last_reg;
    turbo_next     = turbo_reg;
    ear_next       = ear_reg;
    done_next      = 1'b0;
    underrun_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ear_next = 1'b0;
        if (i_blk_start) begin
          turbo_next     = i_save_turbo;
          pilot_cnt_next = i_blk_is_hdr ? PILOT_HDR_M1 : PILOT_DAT_M1;
          len_cnt_next   = reload(PILOT_T, i_save_turbo);
          ear_next       = 1'b1;
          state_next     = ST_PILOT;
        end
      end

      ST_PILOT: begin
        if (i_tstate_en) begin
          if (len_cnt_reg == '0) begin
            ear_next = ~ear_reg;
            if (pilot_cnt_reg == '0) begin
              len_cnt_next = reload(SYNC1_T, turbo_reg);
              state_next   = ST_SYNC1;
            end else begin
              pilot_cnt_next = pilot_cnt_reg - 13'd1;
              len_cnt_next   = reload(PILOT_T, turbo_reg);
            end
          end else begin
            len_cnt_next = len_cnt_reg - 22'd1;
          end
        end
      end

      ST_SYNC1: begin
        if (i_tstate_en) begin
          if (len_cnt_reg == '0) begin
            ear_next     = ~ear_reg;
            len_cnt_next = reload(SYNC2_T, turbo_reg);
            state_next   = ST_SYNC2;
          end else begin
            len_cnt_next = len_cnt_reg - 22'd1;
          end
        end
      end

      ST_SYNC2: begin
        if (i_tstate_en) begin
          if (len_cnt_reg == '0) begin
            ear_next   = ~ear_reg;
            state_next = ST_LOAD;
          end else begin
            len_cnt_next = len_cnt_reg - 22'd1;
          end
        end
      end

      // The LOAD cycle already belongs to the first pulse of bit 7, so its strobe is counted.
      ST_LOAD: begin
        if (i_data_valid) begin
          byte_next    = i_data;
          last_next    = i_data_last;
          bit_idx_next = 3'd7;
          half_next    = 1'b0;
          len_cnt_next = reload(i_data[7] ? BIT1_T : BIT0_T, turbo_reg)
                         - {21'd0, i_tstate_en};
          state_next   = ST_DATA;
        end else begin
          underrun_next = 1'b1;
          ear_next      = 1'b0;
          len_cnt_next  = PAUSE_M1;
          state_next    = ST_PAUSE;
        end
      end

      ST_DATA: begin
        if (i_tstate_en) begin
          if (len_cnt_reg == '0) begin
            ear_next = ~ear_reg;
            if (!half_reg) begin
              half_next    = 1'b1;
              len_cnt_next = reload(byte_reg[7] ? BIT1_T : BIT0_T, turbo_reg);
            end else if (bit_idx_reg == '0) begin
              if (last_reg) begin
                ear_next     = 1'b0;
                len_cnt_next = PAUSE_M1;
                state_next   = ST_PAUSE;
              end else begin
                state_next = ST_LOAD;
              end
            end else begin
              bit_idx_next = bit_idx_reg - 3'd1;
              half_next    = 1'b0;
              byte_next    = {byte_reg[6:0], 1'b0};
              len_cnt_next = reload(byte_reg[6] ? BIT1_T : BIT0_T, turbo_reg);
            end
          end else begin
            len_cnt_next = len_cnt_reg - 22'd1;
          end
        end
      end

      ST_PAUSE: begin
        ear_next = 1'b0;
        if (i_tstate_en) begin
          if (len_cnt_reg == '0) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            len_cnt_next = len_cnt_reg - 22'd1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign o_data_ready = (state_reg == ST_LOAD);
  assign o_busy       = (state_reg != ST_IDLE);
  assign o_ear        = ear_reg;
  assign o_done       = done_reg;
  assign o_underrun   = underrun_reg;

endmodule
